sbin_window: RTL
================

Name: sbin_window

Overview:
- Windowed stochastic-to-binary decoder. It sits directly downstream of stanh, or of any stochastic stage, in the sng -> stanh -> decoder chain.
- On command, it discards a programmable warm-up run of bits so the upstream FSM can settle. It then counts ones in bit_in over a fixed window of 2^N clocks.
- The saturated N-bit count is presented with a one-cycle valid strobe.
- A continuous mode re-arms the block back-to-back for streaming measurement.

Parameters:
- N, 10, window length is 2^N cycles; also the result width.
- WARMUP, 16, number of cycles bit_in is ignored after each start or re-arm. 0 means no warm-up. Range 0..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- start  input  1  begin one measurement; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at window end.
- bit_in  input  1  stochastic bitstream from the upstream stage.
- value  output  N  decoded ones-count of the last completed window, saturated.
- valid  output  1  one-cycle strobe; value updated this cycle.
- sat  output  1  last window count was 2^N, clamped to 2^N-1; held with value.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; value=0, valid=0, sat=0, busy=0.
  - Internal warm-up counter and window counter = 0; accumulator = 0.
  - Release of rst takes effect at the next rising edge.
- States: IDLE, WARM, ACC.
- IDLE:
  - Edge with start=1 -> WARM if WARMUP>0, else ACC.
  - Warm-up counter, window counter and accumulator (N+1 bits) are cleared on that edge.
- WARM:
  - bit_in ignored; warm-up counter increments each edge.
  - On the edge where WARMUP cycles have elapsed -> ACC.
  - With start sampled at edge k, the WARM cycles are edges k+1..k+WARMUP.
- ACC:
  - Each edge: accumulator += bit_in; window counter increments.
  - Exactly 2^N samples are taken: edges k+WARMUP+1 .. k+WARMUP+2^N.
  - On the edge taking the final sample:
    - value <= min(acc+bit_in, 2^N-1);
    - sat <= (acc+bit_in == 2^N);
    - valid <= 1 for exactly the following cycle.
  - On that same edge:
    - cont=1 -> clear counters/accumulator, go to WARM (or ACC if WARMUP=0); the first sample of the new window is taken one edge later, with no gap beyond the warm-up.
    - cont=0 -> IDLE.
- valid=0 on every other cycle.
- value and sat hold their last result until the next completion or reset.
- start while busy=1 is ignored; it is neither queued nor restarts the window.
- start and completion on the same edge: completion wins; start is ignored because state is not IDLE.
- Accumulator is N+1 bits wide; it never wraps.
- Counters are sized for 2^N and WARMUP with no overflow.
- Deasserting cont mid-window is legal; only its value at window end matters.
- rst asserted mid-WARM/ACC: partial window discarded; value/sat forced to 0; valid never pulses for the aborted window.
- X on bit_in in IDLE/WARM must not propagate into value.

Test Plan:
- N=4, WARMUP=2; start pulse at edge k, bit_in=1 constant:
  - busy rises after edge k;
  - valid high only in the cycle after edge k+18;
  - value=15, sat=1;
  - busy low after edge k+18.
- N=4, WARMUP=2:
  - bit_in=0 constant -> value=0, sat=0.
  - bit_in alternating 1,0 starting at first ACC sample -> value=8.
  - bit_in=1 during WARM only, 0 during ACC -> value=0 (warm-up bits ignored).
- N=4, WARMUP=0, cont=1, bit_in = 1 for 3 of every 4 cycles:
  - valid strobes every 16 cycles, with no idle gap;
  - each value=12;
  - clearing cont mid-window -> exactly one more strobe, then busy=0.
- N=4: start re-pulsed at several points while busy -> single strobe at the original timing; result unchanged.
- N=4: rst pulsed mid-ACC (6th sample) with a prior value=8 held:
  - value=0, sat=0, busy=0 immediately, without waiting for a clock;
  - no valid strobe;
  - a new start then yields a correct full window.
- Full chain, N=10, WARMUP=16 (default): sng x=10'h200 -> stanh -> sbin_window:
  - one valid strobe 1+16+1024 cycles after start;
  - value within tanh-stage expected range ±16 LSB;
  - busy/valid exclusive of the IDLE state.

Source files
------------

// File: rtl/sbin_window_if.sv
// rtl/sbin_window_if.sv - control, bitstream and result signals of the windowed decoder
//
// Purpose: bundles every sbin_window signal except clk/rst.
// Signals:
//   start  : begin one measurement (acted on only when idle)
//   cont   : continuous re-arm, looked at on the window-end edge
//   bit_in : stochastic bitstream from the upstream stage
//   value  : saturated N-bit ones-count of the last completed window
//   valid  : one-cycle strobe, value/sat updated this cycle
//   sat    : last window counted 2^N and was clamped to 2^N-1
//   busy   : block is warming up or accumulating
// Modports: master drives start/cont/bit_in, slave (the decoder) drives the results.
interface sbin_window_if #(
  parameter int N = 10
);
  logic         start;
  logic         cont;
  logic         bit_in;
  logic [N-1:0] value;
  logic         valid;
  logic         sat;
  logic         busy;

  modport master (output start, output cont, output bit_in,
                  input value, input valid, input sat, input busy);
  modport slave  (input start, input cont, input bit_in,
                  output value, output valid, output sat, output busy);
endinterface

// File: rtl/sbin_window.sv
// rtl/sbin_window.sv - windowed stochastic-to-binary decoder with warm-up and continuous mode
//
// Purpose: after start, ignores WARMUP bits, then counts ones in bit_in over
// 2^N clocks and publishes the saturated count with a one-cycle valid strobe.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sbin_window_if slave (start, cont, bit_in in; value, valid, sat, busy out)
// Parameters:
//   N      : window is 2^N cycles, result width N
//   WARMUP : cycles ignored after each start or re-arm (0 = none)
module sbin_window #(
  parameter int N      = 10,
  parameter int WARMUP = 16
) (
  input  logic         clk,
  input  logic         rst,
  sbin_window_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    ACC  = 2'd2
  } state_t;

  // Warm-up counter only needs to reach WARMUP-1; keep at least one bit.
  localparam int             WW        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0]  WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [N-1:0]   WIN_LAST  = {N{1'b1}};
  localparam state_t         FIRST_ST  = (WARMUP > 0) ? WARM : ACC;

  state_t        state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [N-1:0]  win_q, win_d;
  logic [N:0]    acc_q, acc_d;
  logic [N-1:0]  value_q, value_d;
  logic          sat_q, sat_d;
  logic          valid_q, valid_d;
  logic [N:0]    sum;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    win_d   = win_q;
    acc_d   = acc_q;
    value_d = value_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    // Only consulted in ACC, so bit_in outside the window never reaches value.
    sum     = acc_q + {{N{1'b0}}, bus.bit_in};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          warm_d  = '0;
          win_d   = '0;
          acc_d   = '0;
          state_d = FIRST_ST;
        end
      end
      WARM: begin
        warm_d = warm_q + 1'b1;
        if (warm_q == WARM_LAST) begin
          warm_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = sum;
        win_d = win_q + 1'b1;
        if (win_q == WIN_LAST) begin
          // sum can reach 2^N at most, so its top bit alone flags saturation.
          value_d = sum[N] ? {N{1'b1}} : sum[N-1:0];
          sat_d   = sum[N];
          valid_d = 1'b1;
          warm_d  = '0;
          win_d   = '0;
          acc_d   = '0;
          state_d = bus.cont ? FIRST_ST : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      warm_q  <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      value_q <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      value_q <= value_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign bus.value = value_q;
  assign bus.sat   = sat_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);

endmodule
